// File: rtl/memory_manager_param.sv
// Data/program memory manager: zero-fills data memory after reset, serves
// single-cycle data reads/writes, exports bank/control words and accepts a program load stream.
module memory_manager_param #(
    parameter int                   WORD_SIZE  = 8,
    parameter int                   INSTR_SIZE = 16,
    parameter int                   DATA_DEPTH = 256,
    parameter int                   PROG_DEPTH = 256,
    parameter int                   NUM_BANKS  = 4,
    parameter logic [WORD_SIZE-1:0] BANK_BASE  = 8'hF0,
    parameter logic [WORD_SIZE-1:0] CTRL_ADDR  = 8'hFF,
    localparam int                  BS_W       = $clog2(NUM_BANKS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [WORD_SIZE-1:0]           pc,
    input  logic [1:0]                     op,
    input  logic [WORD_SIZE-1:0]           addr,
    input  logic [WORD_SIZE-1:0]           write_data,
    output logic [WORD_SIZE-1:0]           read_data,
    output logic                           read_valid,
    output logic [INSTR_SIZE-1:0]          current_instruction,
    output logic [NUM_BANKS*WORD_SIZE-1:0] banks,
    output logic [BS_W-1:0]                bank_sel,
    output logic                           mem_ready,
    output logic                           mem_err,
    input  logic                           load_req,
    input  logic                           prog_valid,
    output logic                           prog_ready,
    input  logic [WORD_SIZE-1:0]           prog_addr,
    input  logic [INSTR_SIZE-1:0]          prog_data
);

    localparam int                   DA_W     = $clog2(DATA_DEPTH);
    localparam int                   PA_W     = $clog2(PROG_DEPTH);
    localparam logic [WORD_SIZE:0]   DATA_LIM = (WORD_SIZE+1)'(DATA_DEPTH);
    localparam logic [WORD_SIZE:0]   PROG_LIM = (WORD_SIZE+1)'(PROG_DEPTH);
    localparam logic [DA_W-1:0]      CLR_LAST = DA_W'(DATA_DEPTH - 1);
    localparam logic [DA_W-1:0]      CNT_ONE  = {{(DA_W-1){1'b0}}, 1'b1};
    localparam logic [DA_W-1:0]      CTRL_IDX = CTRL_ADDR[DA_W-1:0];

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DA_W-1:0]       r_clr_cnt;
    logic                  r_load_pend;
    logic                  w_load_pend_next;
    logic [WORD_SIZE-1:0]  r_read_data;
    logic                  r_read_valid;
    logic                  r_mem_err;

    logic [WORD_SIZE-1:0]  r_data_mem [DATA_DEPTH];
    logic [INSTR_SIZE-1:0] r_prog_mem [PROG_DEPTH];

    logic                  w_clear;
    logic                  w_run;
    logic                  w_load;
    logic                  w_addr_ok;
    logic                  w_pc_ok;
    logic                  w_paddr_ok;
    logic                  w_data_we;
    logic [DA_W-1:0]       w_data_wa;
    logic [WORD_SIZE-1:0]  w_data_wd;
    logic                  w_prog_we;
    logic                  w_data_err;
    logic                  w_prog_err;

    assign w_clear    = (r_state == ST_CLEAR);
    assign w_run      = (r_state == ST_RUN);
    assign w_load     = (r_state == ST_LOAD);
    assign w_addr_ok  = ({1'b0, addr} < DATA_LIM);
    assign w_pc_ok    = ({1'b0, pc} < PROG_LIM);
    assign w_paddr_ok = ({1'b0, prog_addr} < PROG_LIM);

    // The clear sweep shares the single data write port with RUN writes.
    assign w_data_we  = w_clear | (w_run & (op == OP_WRITE) & w_addr_ok);
    assign w_data_wa  = w_clear ? r_clr_cnt : addr[DA_W-1:0];
    assign w_data_wd  = w_clear ? '0 : write_data;
    assign w_prog_we  = w_load & prog_valid & w_paddr_ok;
    assign w_data_err = w_run & ((op == OP_RSVD) | ((op != OP_NOP) & ~w_addr_ok));
    assign w_prog_err = w_load & prog_valid & ~w_paddr_ok;

    // Next-state logic; a load request that collides with an op is remembered for one cycle.
    always_comb begin
        w_state_next     = r_state;
        w_load_pend_next = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_cnt == CLR_LAST) w_state_next = ST_RUN;
                else                       w_state_next = ST_CLEAR;
            end
            ST_RUN: begin
                if (load_req && ((op == OP_NOP) || r_load_pend)) begin
                    w_state_next = ST_LOAD;
                end else begin
                    w_state_next     = ST_RUN;
                    w_load_pend_next = load_req;
                end
            end
            ST_LOAD: begin
                if (load_req) w_state_next = ST_LOAD;
                else          w_state_next = ST_RUN;
            end
            default: w_state_next = ST_CLEAR;
        endcase
    end

    // State, clear counter and registered read/error outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_CLEAR;
            r_clr_cnt    <= '0;
            r_load_pend  <= 1'b0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_mem_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_load_pend  <= w_load_pend_next;
            r_clr_cnt    <= w_clear ? (r_clr_cnt + CNT_ONE) : '0;
            r_read_valid <= w_run & (op == OP_READ);
            r_mem_err    <= w_data_err | w_prog_err;
            if (w_run && (op == OP_READ)) begin
                r_read_data <= w_addr_ok ? r_data_mem[addr[DA_W-1:0]] : '0;
            end else begin
                r_read_data <= r_read_data;
            end
        end
    end

    // Data memory write port.
    always_ff @(posedge clk) begin
        if (w_data_we) r_data_mem[w_data_wa] <= w_data_wd;
    end

    // Program memory write port; deliberately outside reset so a program survives it.
    always_ff @(posedge clk) begin
        if (w_prog_we) r_prog_mem[prog_addr[PA_W-1:0]] <= prog_data;
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        localparam logic [DA_W-1:0] BIDX = DA_W'(int'(BANK_BASE) + g);
        assign banks[g*WORD_SIZE +: WORD_SIZE] = w_clear ? '0 : r_data_mem[BIDX];
    end

    assign bank_sel            = w_clear ? '0 : r_data_mem[CTRL_IDX][BS_W-1:0];
    assign current_instruction = (w_run && w_pc_ok) ? r_prog_mem[pc[PA_W-1:0]] : '0;
    assign read_data           = r_read_data;
    assign read_valid          = r_read_valid;
    assign mem_err             = r_mem_err;
    assign mem_ready           = w_run;
    assign prog_ready          = w_load;

endmodule

// File: tb/tb_memory_manager_param.sv
// Scoreboard bench for memory_manager_param: randomized ops against an array model,
// read/error expectations queued by the driver and retired by a negedge monitor.
module tb_memory_manager_param;

    localparam int PD = 128;
    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_RD  = 2'd1;

    logic        clk;
    logic        reset;
    logic [7:0]  pc;
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        read_valid;
    logic [15:0] current_instruction;
    logic [31:0] banks;
    logic [1:0]  bank_sel;
    logic        mem_ready;
    logic        mem_err;
    logic        load_req;
    logic        prog_valid;
    logic        prog_ready;
    logic [7:0]  prog_addr;
    logic [15:0] prog_data;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } rd_exp_t;

    rd_exp_t     q_rd[$];
    int          q_err[$];
    logic [7:0]  mdl_data[256];
    logic [15:0] mdl_prog[PD];
    bit          mdl_pv[PD];
    logic [7:0]  hold_exp;
    rd_exp_t     mon_e;
    int          mon_c;
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    memory_manager_param #(.PROG_DEPTH(PD)) dut (
        .clk(clk), .reset(reset), .pc(pc), .op(op), .addr(addr),
        .write_data(write_data), .read_data(read_data), .read_valid(read_valid),
        .current_instruction(current_instruction), .banks(banks), .bank_sel(bank_sel),
        .mem_ready(mem_ready), .mem_err(mem_err), .load_req(load_req),
        .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_addr(prog_addr),
        .prog_data(prog_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: retires queued expectations whenever the DUT presents read_valid or mem_err.
    always @(negedge clk) begin
        if (read_valid) begin
            if (q_rd.size() == 0) begin
                chk("rd_unexpected", 32'(read_valid), 32'd0);
            end else begin
                mon_e = q_rd.pop_front();
                chk("rd_data", 32'(read_data), 32'(mon_e.data));
                chk("rd_latency", 32'(cyc), 32'(mon_e.cyc));
                hold_exp = mon_e.data;
            end
        end else begin
            chk("rd_hold", 32'(read_data), 32'(hold_exp));
            if (q_rd.size() != 0 && q_rd[0].cyc <= cyc) begin
                chk("rd_missing", 32'(read_valid), 32'd1);
                q_rd.delete(0);
            end
        end
        if (mem_err) begin
            if (q_err.size() == 0) begin
                chk("err_unexpected", 32'(mem_err), 32'd0);
            end else begin
                mon_c = q_err.pop_front();
                chk("err_latency", 32'(cyc), 32'(mon_c));
            end
        end else if (q_err.size() != 0 && q_err[0] <= cyc) begin
            chk("err_missing", 32'(mem_err), 32'd1);
            q_err.delete(0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_banks();
        chk("banks", banks, {mdl_data[243], mdl_data[242], mdl_data[241], mdl_data[240]});
        chk("bank_sel", 32'(bank_sel), 32'(mdl_data[255][1:0]));
    endtask

    task automatic chk_instr();
        if (int'(pc) >= PD) chk("instr_oob", 32'(current_instruction), 32'd0);
        else if (mdl_pv[pc[6:0]]) chk("instr", 32'(current_instruction), 32'(mdl_prog[pc[6:0]]));
        else begin end
    endtask

    task automatic issue(input int o, input int a, input int d);
        rd_exp_t e;
        op = 2'(o); addr = 8'(a); write_data = 8'(d);
        if (o == 1) begin
            e.data = mdl_data[a]; e.cyc = cyc + 1;
            q_rd.push_back(e);
        end else if (o == 2) begin
            mdl_data[a] = 8'(d);
        end else if (o == 3) begin
            q_err.push_back(cyc + 1);
        end else begin end
        #1 chk_instr();
        tick();
        op = OP_NOP;
        chk_banks();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        q_rd.delete(); q_err.delete(); hold_exp = 8'h00;
        op = OP_NOP; load_req = 1'b0; prog_valid = 1'b0;
        #1;
        chk("rst_read_data", 32'(read_data), 32'd0);
        chk("rst_read_valid", 32'(read_valid), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_prog_ready", 32'(prog_ready), 32'd0);
        chk("rst_banks", banks, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic run_clear(input int stop_at, output int n);
        n = 0;
        while (mem_ready !== 1'b1 && n < stop_at) begin
            op = 2'($urandom_range(0, 3)); addr = 8'($urandom); write_data = 8'($urandom);
            pc = 8'($urandom);
            tick();
            n++;
            if (n == 1) begin
                chk("clear_banks", banks, 32'd0);
                chk("clear_bank_sel", 32'(bank_sel), 32'd0);
                chk("clear_instr", 32'(current_instruction), 32'd0);
                chk("clear_prog_ready", 32'(prog_ready), 32'd0);
            end
        end
        op = OP_NOP;
        if (mem_ready === 1'b1) foreach (mdl_data[i]) mdl_data[i] = 8'h00;
    endtask

    task automatic readback_all();
        for (int a = 0; a < 256; a++) issue(1, a, 0);
    endtask

    task automatic pc_sweep();
        for (int p = 0; p < 256; p++) begin
            pc = 8'(p);
            @(negedge clk);
            chk_instr();
        end
    endtask

    task automatic prog_beat(input int a, input int d, input bit last);
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
            prog_valid = 1'b0;
            op = 2'($urandom_range(0, 3)); addr = 8'($urandom); write_data = 8'($urandom);
            #1 chk("instr_in_load", 32'(current_instruction), 32'd0);
            tick();
        end
        op = OP_NOP; prog_valid = 1'b1; prog_addr = 8'(a); prog_data = 16'(d);
        if (last) load_req = 1'b0;
        if (a >= PD) q_err.push_back(cyc + 1);
        chk("prog_ready_load", 32'(prog_ready), 32'd1);
        tick();
        prog_valid = 1'b0;
        if (a < PD) begin
            mdl_prog[a] = 16'(d);
            mdl_pv[a]   = 1'b1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; op = OP_NOP; addr = 8'h00; write_data = 8'h00; pc = 8'h00;
        load_req = 1'b0; prog_valid = 1'b0; prog_addr = 8'h00; prog_data = 16'h0000;
        hold_exp = 8'h00;
        foreach (mdl_pv[i]) mdl_pv[i] = 1'b0;
        foreach (mdl_data[i]) mdl_data[i] = 8'h00;
        #2;
        apply_reset();
        run_clear(1000, n);
        chk("clear_cycles", 32'(n), 32'd256);
        readback_all();

        issue(2, 16, 'h5A);
        issue(1, 16, 0);
        issue(2, 255, 'h03);
        issue(2, 243, 'hAA);
        chk("bank_sel_3", 32'(bank_sel), 32'd3);
        chk("bank3_aa", 32'(banks[31:24]), 32'h0000_00AA);
        issue(3, 32, 'h77);
        issue(1, 32, 0);

        // load request that collides with a read: the read runs first
        load_req = 1'b1;
        issue(1, 16, 0);
        chk("load_defer_ready", 32'(mem_ready), 32'd1);
        chk("load_defer_pr", 32'(prog_ready), 32'd0);
        tick();
        chk("load_entry_pr", 32'(prog_ready), 32'd1);
        chk("load_entry_ready", 32'(mem_ready), 32'd0);
        prog_beat(0, 'h1234, 1'b0);
        prog_beat(1, 'hBEEF, 1'b0);
        for (int a = 2; a < 127; a++) prog_beat(a, int'($urandom_range(0, 65535)), 1'b0);
        prog_beat(200, 'hDEAD, 1'b0);
        prog_beat(127, int'($urandom_range(0, 65535)), 1'b1);
        chk("load_exit_pr", 32'(prog_ready), 32'd0);
        chk("load_exit_ready", 32'(mem_ready), 32'd1);
        pc = 8'd1;
        #1 chk("instr_beef", 32'(current_instruction), 32'h0000_BEEF);
        pc = 8'd0;
        #1 chk("instr_1234", 32'(current_instruction), 32'h0000_1234);

        for (int i = 0; i < 600; i++) begin
            int sel;
            int a;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       a = int'($urandom_range(0, 255));
                1:       a = 240 + int'($urandom_range(0, 3));
                2:       a = 255;
                default: a = 16 + int'($urandom_range(0, 3));
            endcase
            pc = 8'($urandom);
            issue(int'($urandom_range(0, 3)), a, int'($urandom_range(0, 255)));
        end

        // in-flight read aborted by reset, then a reset part way through the clear
        op = OP_RD; addr = 8'd16;
        #2 apply_reset();
        run_clear(100, n);
        chk("clear_partial_n", 32'(n), 32'd100);
        chk("clear_partial_ready", 32'(mem_ready), 32'd0);
        #2 apply_reset();
        run_clear(1000, n);
        chk("clear_restart", 32'(n), 32'd256);
        readback_all();
        pc_sweep();

        // reset during a program load
        load_req = 1'b1;
        tick();
        chk("load2_entry_pr", 32'(prog_ready), 32'd1);
        prog_beat(5, int'($urandom_range(0, 65535)), 1'b0);
        prog_beat(6, int'($urandom_range(0, 65535)), 1'b0);
        prog_valid = 1'b1; prog_addr = 8'd7; prog_data = ~mdl_prog[7];
        #2 apply_reset();
        run_clear(1000, n);
        chk("clear_after_load", 32'(n), 32'd256);
        pc_sweep();
        issue(1, 243, 0);
        tick();
        tick();
        chk("q_rd_drained", 32'(q_rd.size()), 32'd0);
        chk("q_err_drained", 32'(q_err.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
